// File: rtl/arr_sched_pkg.sv
// Shared types and constants for the core-memory array schedulers.
package arr_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StFin
    } sched_state_e;

    // Bank select values carried in the core-memory address MSB.
    localparam logic BANK_WMEM  = 1'b0;
    localparam logic BANK_CACHE = 1'b1;

    // Width of the saturating stall counter.
    localparam int unsigned STALL_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cmem_rd_sched_if.sv
// Configuration, conflict-monitor and read-channel signals of the core-memory read scheduler.
interface cmem_rd_sched_if
    import arr_sched_pkg::*;
#(
    parameter int unsigned GBUS_ADDR = 16,
    parameter int unsigned LEN_W     = 12,
    parameter int unsigned STRIDE_W  = 8,
    parameter int unsigned PASS_W    = 4
);
    // Job configuration from the core controller.
    logic                   cfg_start;
    logic                   cfg_abort;
    logic [GBUS_ADDR-1:0]   cfg_base;
    logic [LEN_W-1:0]       cfg_len;
    logic [STRIDE_W-1:0]    cfg_stride;
    logic [PASS_W-1:0]      cfg_passes;

    // Competing traffic on the single-port memories.
    logic                   gbus_ren;
    logic                   gbus_wen;
    logic                   gbus_addr_msb;
    logic                   cmem_wen;
    logic                   cmem_waddr_msb;
    logic                   lbuf_almost_full;

    // Read channel and status.
    logic [GBUS_ADDR-1:0]   cmem_raddr;
    logic                   cmem_ren;
    logic                   busy;
    logic                   done;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport slave (
        input  cfg_start, cfg_abort, cfg_base, cfg_len, cfg_stride, cfg_passes,
        input  gbus_ren, gbus_wen, gbus_addr_msb, cmem_wen, cmem_waddr_msb, lbuf_almost_full,
        output cmem_raddr, cmem_ren, busy, done, stall_cycles
    );

    modport master (
        output cfg_start, cfg_abort, cfg_base, cfg_len, cfg_stride, cfg_passes,
        output gbus_ren, gbus_wen, gbus_addr_msb, cmem_wen, cmem_waddr_msb, lbuf_almost_full,
        input  cmem_raddr, cmem_ren, busy, done, stall_cycles
    );

endinterface

// File: rtl/sched_addr_gen.sv
// Strided, bank-preserving address counter with word index and pass counters.
module sched_addr_gen #(
    parameter int unsigned GBUS_ADDR = 16,
    parameter int unsigned LEN_W     = 12,
    parameter int unsigned STRIDE_W  = 8,
    parameter int unsigned PASS_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 advance,
    input  logic [GBUS_ADDR-1:0] cfg_base,
    input  logic [LEN_W-1:0]     cfg_len,
    input  logic [STRIDE_W-1:0]  cfg_stride,
    input  logic [PASS_W-1:0]    cfg_passes,
    output logic [GBUS_ADDR-1:0] addr,
    output logic                 last
);
    localparam int unsigned LOW_W = GBUS_ADDR - 1;

    logic                bank_q;
    logic [LOW_W-1:0]    base_low_q;
    logic [LOW_W-1:0]    low_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx_q;
    logic [PASS_W-1:0]   pass_q;
    logic [PASS_W-1:0]   last_pass_q;
    logic                pass_end;

    // End of pass and end of job, decoded from the counters.
    always_comb begin
        pass_end = (idx_q == len_q - 1'b1);
        last     = pass_end && (pass_q == last_pass_q);
        addr     = {bank_q, low_q};
    end

    // Counter state: load on start, step on each issued word.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q      <= 1'b0;
            base_low_q  <= '0;
            low_q       <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            pass_q      <= '0;
            last_pass_q <= '0;
        end else if (load) begin
            bank_q      <= cfg_base[GBUS_ADDR-1];
            base_low_q  <= cfg_base[LOW_W-1:0];
            low_q       <= cfg_base[LOW_W-1:0];
            stride_q    <= cfg_stride;
            len_q       <= cfg_len;
            idx_q       <= '0;
            pass_q      <= '0;
            // A pass count of zero runs a single pass.
            last_pass_q <= (cfg_passes == '0) ? '0 : cfg_passes - 1'b1;
        end else if (advance) begin
            if (pass_end) begin
                idx_q <= '0;
                low_q <= base_low_q;
                if (!last) begin
                    pass_q <= pass_q + 1'b1;
                end
            end else begin
                idx_q <= idx_q + 1'b1;
                // Low field wraps inside the bank; bank_q is never touched here.
                low_q <= low_q + LOW_W'(stride_q);
            end
        end
    end

endmodule

// File: rtl/cmem_rd_sched.sv
// Core-memory MAC read scheduler: streams strided WMEM/KV-cache reads into the LBUF,
// yielding to GBUS and write-back traffic and throttling on LBUF backpressure.
module cmem_rd_sched
    import arr_sched_pkg::*;
#(
    parameter int unsigned GBUS_ADDR = 16,
    parameter int unsigned LEN_W     = 12,
    parameter int unsigned STRIDE_W  = 8,
    parameter int unsigned PASS_W    = 4
) (
    input logic             clk,
    input logic             rst,
    cmem_rd_sched_if.slave  bus
);
    sched_state_e           state_q;
    sched_state_e           state_d;
    logic [GBUS_ADDR-1:0]   addr;
    logic                   last;
    logic                   bank;
    logic                   gbus_hit;
    logic                   wb_hit;
    logic                   stall;
    logic                   issue;
    logic                   load;
    logic [STALL_CNT_W-1:0] stall_q;

    sched_addr_gen #(
        .GBUS_ADDR (GBUS_ADDR),
        .LEN_W     (LEN_W),
        .STRIDE_W  (STRIDE_W),
        .PASS_W    (PASS_W)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .advance    (issue),
        .cfg_base   (bus.cfg_base),
        .cfg_len    (bus.cfg_len),
        .cfg_stride (bus.cfg_stride),
        .cfg_passes (bus.cfg_passes),
        .addr       (addr),
        .last       (last)
    );

    // Conflict detection and read strobe, live from the competing requests.
    always_comb begin
        bank     = addr[GBUS_ADDR-1];
        gbus_hit = (bus.gbus_ren | bus.gbus_wen) & (bus.gbus_addr_msb == bank);
        // WMEM write-back uses a separate port, so only cache write-back collides.
        wb_hit   = bus.cmem_wen & (bus.cmem_waddr_msb == bank) & (bank == BANK_CACHE);
        stall    = bus.lbuf_almost_full | gbus_hit | wb_hit;
        issue    = (state_q == StIssue) & ~stall & ~bus.cfg_abort;
        load     = (state_q == StIdle) & bus.cfg_start;
    end

    // Next-state logic; start beats abort in IDLE, abort wins everywhere else.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.cfg_start) begin
                    // Zero-length jobs still pass through DRAIN so done lands at start+2.
                    state_d = (bus.cfg_len == '0) ? StDrain : StIssue;
                end
            end
            StIssue: begin
                if (bus.cfg_abort) begin
                    state_d = StIdle;
                end else if (issue && last) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                state_d = bus.cfg_abort ? StIdle : StFin;
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Saturating count of ISSUE cycles lost to conflicts or backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (load) begin
            stall_q <= '0;
        end else if ((state_q == StIssue) && stall) begin
            stall_q <= sat_inc(stall_q);
        end
    end

    // Output mapping.
    always_comb begin
        bus.cmem_ren     = issue;
        bus.cmem_raddr   = addr;
        bus.busy         = (state_q != StIdle);
        bus.done         = (state_q == StFin) & ~bus.cfg_abort;
        bus.stall_cycles = stall_q;
    end

endmodule

// File: tb/tb_cmem_rd_sched.sv
// Directed self-checking bench for cmem_rd_sched.
module tb_cmem_rd_sched;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    cmem_rd_sched_if bus ();

    cmem_rd_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.cfg_start        = 1'b0;
        bus.cfg_abort        = 1'b0;
        bus.gbus_ren         = 1'b0;
        bus.gbus_wen         = 1'b0;
        bus.gbus_addr_msb    = 1'b0;
        bus.cmem_wen         = 1'b0;
        bus.cmem_waddr_msb   = 1'b0;
        bus.lbuf_almost_full = 1'b0;
    endtask

    // Pulses start for one cycle; returns just after the edge that enters the job.
    task automatic start_job(input logic [15:0] base, input logic [11:0] len,
                             input logic [7:0] stride, input logic [3:0] passes);
        bus.cfg_base   = base;
        bus.cfg_len    = len;
        bus.cfg_stride = stride;
        bus.cfg_passes = passes;
        bus.cfg_start  = 1'b1;
        tick();
        bus.cfg_start  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        start_job(16'h1234, 12'd4, 8'd1, 4'd1);
        bus.cfg_start = 1'b1;
        tick();
        @(negedge clk);
        checks += 5;
        if (bus.cmem_ren !== 1'b0) begin
            failures++; $display("FAIL reset_ren got=%b exp=0", bus.cmem_ren);
        end
        if (bus.cmem_raddr !== 16'h0000) begin
            failures++; $display("FAIL reset_raddr got=%h exp=0000", bus.cmem_raddr);
        end
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        if (bus.done !== 1'b0) begin
            failures++; $display("FAIL reset_done got=%b exp=0", bus.done);
        end
        if (bus.stall_cycles !== 16'd0) begin
            failures++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cycles);
        end
        bus.cfg_start = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_pass();
        start_job(16'h0010, 12'd4, 8'd1, 4'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.cmem_ren !== 1'b1 || bus.busy !== 1'b1 || bus.cmem_raddr !== 16'h0010 + 16'(k)) begin
                failures++;
                $display("FAIL single_issue%0d got ren=%b busy=%b addr=%h exp ren=1 busy=1 addr=%h",
                         k, bus.cmem_ren, bus.busy, bus.cmem_raddr, 16'h0010 + 16'(k));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.cmem_ren !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL single_drain got ren=%b busy=%b done=%b exp 0/1/0",
                     bus.cmem_ren, bus.busy, bus.done);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.stall_cycles !== 16'd0) begin
            failures++;
            $display("FAIL single_done got done=%b busy=%b stall=%0d exp 1/1/0",
                     bus.done, bus.busy, bus.stall_cycles);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got done=%b busy=%b exp 0/0", bus.done, bus.busy);
        end
    endtask

    // Checks a contiguous run of issues, then DRAIN and the done pulse.
    task automatic test_multi_pass();
        logic [15:0] exp_addr [6];
        exp_addr = '{16'h8000, 16'h8002, 16'h8004, 16'h8000, 16'h8002, 16'h8004};
        start_job(16'h8000, 12'd3, 8'd2, 4'd2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (bus.cmem_ren !== 1'b1 || bus.cmem_raddr !== exp_addr[k]) begin
                failures++;
                $display("FAIL multi_issue%0d got ren=%b addr=%h exp ren=1 addr=%h",
                         k, bus.cmem_ren, bus.cmem_raddr, exp_addr[k]);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.cmem_ren !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL multi_drain got ren=%b done=%b exp 0/0", bus.cmem_ren, bus.done);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++; $display("FAIL multi_done got=%b exp=1", bus.done);
        end
        tick();
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr [3];
        exp_addr = '{16'h7FFE, 16'h7FFF, 16'h0000};
        start_job(16'h7FFE, 12'd3, 8'd1, 4'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.cmem_ren !== 1'b1 || bus.cmem_raddr !== exp_addr[k]) begin
                failures++;
                $display("FAIL wrap_issue%0d got ren=%b addr=%h exp ren=1 addr=%h",
                         k, bus.cmem_ren, bus.cmem_raddr, exp_addr[k]);
            end
            tick();
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++; $display("FAIL wrap_done got=%b exp=1", bus.done);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic        gren [7];
        logic        gmsb [7];
        logic        cwen [7];
        logic        exp_ren [7];
        logic [15:0] exp_addr [7];
        gren     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        gmsb     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cwen     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_ren  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_addr = '{16'h8100, 16'h8100, 16'h8100, 16'h8100, 16'h8101, 16'h8102, 16'h8103};
        start_job(16'h8100, 12'd4, 8'd1, 4'd1);
        for (int k = 0; k < 7; k++) begin
            bus.gbus_ren       = gren[k];
            bus.gbus_addr_msb  = gmsb[k];
            bus.cmem_wen       = cwen[k];
            bus.cmem_waddr_msb = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.cmem_ren !== exp_ren[k] || bus.cmem_raddr !== exp_addr[k]) begin
                failures++;
                $display("FAIL conflict_cyc%0d got ren=%b addr=%h exp ren=%b addr=%h",
                         k, bus.cmem_ren, bus.cmem_raddr, exp_ren[k], exp_addr[k]);
            end
            tick();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (bus.cmem_ren !== 1'b0) begin
            failures++; $display("FAIL conflict_drain got ren=%b exp=0", bus.cmem_ren);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.stall_cycles !== 16'd3) begin
            failures++;
            $display("FAIL conflict_done got done=%b stall=%0d exp done=1 stall=3",
                     bus.done, bus.stall_cycles);
        end
        tick();
    endtask

    // Backpressure mid-job, with WMEM write-back that must not stall a WMEM read.
    task automatic test_lbuf();
        int n;
        bit done_seen;
        logic [15:0] exp;
        n = 0;
        done_seen = 1'b0;
        start_job(16'h0200, 12'd4, 8'd1, 4'd2);
        for (int c = 0; c < 40; c++) begin
            bus.lbuf_almost_full = (c >= 2 && c < 7);
            bus.cmem_wen         = (c < 2);
            bus.cmem_waddr_msb   = 1'b0;
            @(negedge clk);
            if (c < 2) begin
                checks++;
                if (bus.cmem_ren !== 1'b1) begin
                    failures++; $display("FAIL lbuf_wb_wmem%0d got ren=%b exp=1", c, bus.cmem_ren);
                end
            end
            if (bus.lbuf_almost_full) begin
                checks++;
                if (bus.cmem_ren !== 1'b0) begin
                    failures++; $display("FAIL lbuf_hold%0d got ren=%b exp=0", c, bus.cmem_ren);
                end
            end
            if (bus.cmem_ren === 1'b1) begin
                exp = 16'h0200 + 16'(n % 4);
                checks++;
                if (bus.cmem_raddr !== exp) begin
                    failures++;
                    $display("FAIL lbuf_addr%0d got=%h exp=%h", n, bus.cmem_raddr, exp);
                end
                n++;
            end
            if (bus.done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
            tick();
        end
        clear_inputs();
        checks += 3;
        if (!done_seen) begin
            failures++; $display("FAIL lbuf_done_timeout got=0 exp=1");
        end
        if (n != 8) begin
            failures++; $display("FAIL lbuf_issue_count got=%0d exp=8", n);
        end
        if (bus.stall_cycles !== 16'd5) begin
            failures++; $display("FAIL lbuf_stall got=%0d exp=5", bus.stall_cycles);
        end
        tick();
    endtask

    task automatic test_abort();
        bit done_seen;
        start_job(16'h0040, 12'd8, 8'd1, 4'd1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.cmem_ren !== 1'b1 || bus.cmem_raddr !== 16'h0040 + 16'(k)) begin
                failures++;
                $display("FAIL abort_pre%0d got ren=%b addr=%h exp ren=1 addr=%h",
                         k, bus.cmem_ren, bus.cmem_raddr, 16'h0040 + 16'(k));
            end
            tick();
        end
        bus.cfg_abort = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmem_ren !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL abort_cycle got ren=%b done=%b exp 0/0", bus.cmem_ren, bus.done);
        end
        tick();
        bus.cfg_abort = 1'b0;
        done_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                checks++;
                if (bus.busy !== 1'b0) begin
                    failures++; $display("FAIL abort_idle got busy=%b exp=0", bus.busy);
                end
            end
            if (bus.done === 1'b1 || bus.cmem_ren === 1'b1) done_seen = 1'b1;
            tick();
        end
        checks++;
        if (done_seen) begin
            failures++; $display("FAIL abort_no_done got activity=1 exp=0");
        end
        start_job(16'h0040, 12'd8, 8'd1, 4'd1);
        @(negedge clk);
        checks++;
        if (bus.cmem_ren !== 1'b1 || bus.cmem_raddr !== 16'h0040) begin
            failures++;
            $display("FAIL abort_restart got ren=%b addr=%h exp ren=1 addr=0040",
                     bus.cmem_ren, bus.cmem_raddr);
        end
        done_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!done_seen) begin
            failures++; $display("FAIL abort_restart_done got=0 exp=1");
        end
        tick();
    endtask

    task automatic test_start_busy();
        start_job(16'h0300, 12'd3, 8'd1, 4'd1);
        bus.cfg_base  = 16'h0500;
        bus.cfg_len   = 12'd6;
        bus.cfg_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (bus.cmem_ren !== 1'b1 || bus.cmem_raddr !== 16'h0300 + 16'(k)) begin
                failures++;
                $display("FAIL busy_start%0d got ren=%b addr=%h exp ren=1 addr=%h",
                         k, bus.cmem_ren, bus.cmem_raddr, 16'h0300 + 16'(k));
            end
            tick();
        end
        bus.cfg_start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmem_ren !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_drain got ren=%b busy=%b exp 0/1", bus.cmem_ren, bus.busy);
        end
        tick();
        tick();
        // Start and abort together in IDLE: the start is honoured.
        bus.cfg_abort = 1'b1;
        start_job(16'h0060, 12'd1, 8'd1, 4'd1);
        bus.cfg_abort = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.cmem_ren !== 1'b1 || bus.cmem_raddr !== 16'h0060) begin
            failures++;
            $display("FAIL start_abort got busy=%b ren=%b addr=%h exp busy=1 ren=1 addr=0060",
                     bus.busy, bus.cmem_ren, bus.cmem_raddr);
        end
        tick();
        tick();
        tick();
    endtask

    task automatic test_boundaries();
        start_job(16'h0070, 12'd0, 8'd1, 4'd1);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.cmem_ren !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL len0_t1 got busy=%b ren=%b done=%b exp 1/0/0",
                     bus.busy, bus.cmem_ren, bus.done);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.cmem_ren !== 1'b0) begin
            failures++;
            $display("FAIL len0_t2 got done=%b ren=%b exp 1/0", bus.done, bus.cmem_ren);
        end
        tick();
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL len0_t3 got busy=%b exp=0", bus.busy);
        end
        // Pass count of zero behaves as one pass.
        start_job(16'h0020, 12'd2, 8'd1, 4'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (bus.cmem_ren !== 1'b1 || bus.cmem_raddr !== 16'h0020 + 16'(k)) begin
                failures++;
                $display("FAIL pass0_issue%0d got ren=%b addr=%h exp ren=1 addr=%h",
                         k, bus.cmem_ren, bus.cmem_raddr, 16'h0020 + 16'(k));
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (bus.cmem_ren !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL pass0_drain got ren=%b busy=%b exp 0/1", bus.cmem_ren, bus.busy);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_job();
        bit activity;
        start_job(16'h0080, 12'd8, 8'd1, 4'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cmem_ren !== 1'b0 ||
            bus.cmem_raddr !== 16'h0000) begin
            failures++;
            $display("FAIL midreset got busy=%b done=%b ren=%b addr=%h exp 0/0/0/0000",
                     bus.busy, bus.done, bus.cmem_ren, bus.cmem_raddr);
        end
        activity = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) activity = 1'b1;
        end
        checks++;
        if (activity) begin
            failures++; $display("FAIL midreset_quiet got activity=1 exp=0");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.cfg_base   = '0;
        bus.cfg_len    = '0;
        bus.cfg_stride = '0;
        bus.cfg_passes = '0;
        test_reset();
        test_single_pass();
        test_multi_pass();
        test_wrap();
        test_conflict();
        test_lbuf();
        test_abort();
        test_start_busy();
        test_boundaries();
        test_reset_mid_job();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
